// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory port, decoder-side
// valid/ready queue head, and the redirect request.
// Optional signal fetch_count exists only when FETCH_PERF_EN is defined.
interface fetch_ctrl_if;
    logic        run;
    logic [7:0]  mem_addr;
    logic [15:0] mem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [7:0]  out_pc;
    logic        redirect;
    logic [7:0]  redirect_pc;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
`endif

    // Fetch controller side
    modport master (
        input  run,
        output mem_addr,
        input  mem_inst,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        input  redirect,
        input  redirect_pc
`ifdef FETCH_PERF_EN
        ,
        output fetch_count
`endif
    );

    // Environment side (memory, decoder, branch unit)
    modport slave (
        output run,
        input  mem_addr,
        output mem_inst,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        output redirect,
        output redirect_pc
`ifdef FETCH_PERF_EN
        ,
        input  fetch_count
`endif
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a byte-address fetch pointer in steps
// of 2, pushes {instruction, address} into a 2-entry queue toward the
// decoder, and flushes/reloads on redirect with a single bubble cycle.
// Optional macro FETCH_PERF_EN adds a saturating 16-bit count of accepted
// pops on bus.fetch_count.
module fetch_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  fpc_q;
    logic [15:0] inst_q [2];
    logic [7:0]  pc_q   [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;

    logic        do_pop;
    logic        do_push;

    // A pop is only meaningful when the head is valid; redirect discards it.
    assign do_pop  = (count_q != 2'd0) && bus.out_ready && !bus.redirect;

    // Push only while fetching with run held; a full queue accepts a push
    // only when the head leaves in the same cycle.
    assign do_push = (state_q == FETCH) && bus.run && !bus.redirect &&
                     ((count_q != 2'd2) || do_pop);

    assign bus.mem_addr  = fpc_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_inst  = inst_q[rd_ptr_q];
    assign bus.out_pc    = pc_q[rd_ptr_q];

    // Fetch pointer, queue storage/pointers and control FSM share one
    // register block so redirect priority is expressed in one place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fpc_q    <= RESET_PC & 8'hFE;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                inst_q[i] <= 16'h0000;
                pc_q[i]   <= 8'h00;
            end
        end else if (bus.redirect) begin
            // Flush and reload; the queue is emptied and the next cycle is
            // a bubble while the new address is presented to memory.
            state_q  <= REDIR;
            fpc_q    <= bus.redirect_pc & 8'hFE;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                inst_q[wr_ptr_q] <= bus.mem_inst;
                pc_q[wr_ptr_q]   <= fpc_q;
                wr_ptr_q         <= ~wr_ptr_q;
                fpc_q            <= fpc_q + 8'd2;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            case (state_q)
                IDLE:    state_q <= bus.run ? FETCH : IDLE;
                FETCH:   state_q <= bus.run ? FETCH : IDLE;
                REDIR:   state_q <= bus.run ? FETCH : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count_q;

    assign bus.fetch_count = fetch_count_q;

    // Count instructions handed to the decoder, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= 16'h0000;
        end else if (do_pop && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_q <= fetch_count_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations, then randomized run/ready/redirect/reset traffic checked
// every cycle against a queue-based behavioural model.
module tb_fetch_ctrl;

    localparam logic [7:0] RST_PC = 8'h00;

    logic clk;
    logic rst;
    fetch_ctrl_if bus();

    logic [15:0] imem [256];
    assign bus.mem_inst = imem[bus.mem_addr];

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] inst;
        logic [7:0]  pc;
    } ent_t;

    ent_t        mq[$];
    logic [7:0]  mfpc  = RST_PC & 8'hFE;
    bit          armed = 1'b0;   // fetching is allowed at this edge
    logic [15:0] mfc   = 16'h0000;

    // Fetch is active at an edge iff the previous edge saw run without redirect.
    always @(posedge clk or posedge rst) begin
        bit   mpop;
        bit   mpush;
        ent_t e;
        if (rst) begin
            mq.delete();
            mfpc  = RST_PC & 8'hFE;
            armed = 1'b0;
            mfc   = 16'h0000;
        end else begin
            if (bus.redirect) begin
                mq.delete();
                mfpc = {bus.redirect_pc[7:1], 1'b0};
            end else begin
                mpop  = (mq.size() != 0) && bus.out_ready;
                mpush = armed && bus.run && ((mq.size() < 2) || mpop);
                if (mpop) begin
                    void'(mq.pop_front());
                    if (mfc != 16'hFFFF) mfc = mfc + 16'd1;
                end
                if (mpush) begin
                    e.inst = imem[mfpc];
                    e.pc   = mfpc;
                    mq.push_back(e);
                    mfpc = mfpc + 8'd2;
                end
            end
            armed = bus.run && !bus.redirect;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        chk("mem_addr", 32'(bus.mem_addr), 32'(mfpc));
        if (mq.size() != 0) begin
            chk("out_pc", 32'(bus.out_pc), 32'(mq[0].pc));
            chk("out_inst", 32'(bus.out_inst), 32'(mq[0].inst));
        end
`ifdef FETCH_PERF_EN
        chk("fetch_count", 32'(bus.fetch_count), 32'(mfc));
`endif
    end

    // Asynchronous reset pulse starting mid-cycle, released on a falling edge
    task automatic pulse_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.run = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
        imem[4] = 16'h7000;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_inst", 32'(bus.out_inst), 32'h0);
        chk("rst_pc", 32'(bus.out_pc), 32'h0);
        chk("rst_addr", 32'(bus.mem_addr), 32'h0);
        rst = 1'b0;

        // Streaming from reset with decoder always ready
        bus.run = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk); chk("s_first_bubble", 32'(bus.out_valid), 32'h0);
        @(negedge clk); chk("s_pc0", 32'(bus.out_pc), 32'h00);
        chk("s_valid0", 32'(bus.out_valid), 32'h1);
        @(negedge clk); chk("s_pc2", 32'(bus.out_pc), 32'h02);
        @(negedge clk); chk("s_pc4", 32'(bus.out_pc), 32'h04);
        chk("s_inst4", 32'(bus.out_inst), 32'h7000);

        // Backpressure: queue fills, pointer stalls, head held
        pulse_reset();
        bus.run = 1'b1; bus.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp_head", 32'(bus.out_pc), 32'h00);
        chk("bp_fpc", 32'(bus.mem_addr), 32'h04);
        bus.out_ready = 1'b1;
        @(negedge clk); chk("bp_rel2", 32'(bus.out_pc), 32'h02);
        @(negedge clk); chk("bp_rel4", 32'(bus.out_pc), 32'h04);
        bus.out_ready = 1'b0;

        // Redirect with two entries queued; odd target rounds down
        bus.redirect = 1'b1; bus.redirect_pc = 8'h21;
        @(negedge clk); bus.redirect = 1'b0;
        chk("rd_flush", 32'(bus.out_valid), 32'h0);
        chk("rd_addr", 32'(bus.mem_addr), 32'h20);
        @(negedge clk); chk("rd_bubble", 32'(bus.out_valid), 32'h0);
        @(negedge clk); chk("rd_first", 32'(bus.out_pc), 32'h20);
        chk("rd_valid", 32'(bus.out_valid), 32'h1);

        // Fetch pointer wraps at the top of the address space
        bus.redirect = 1'b1; bus.redirect_pc = 8'hFE; bus.out_ready = 1'b1;
        @(negedge clk); bus.redirect = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("wrap_fe", 32'(bus.out_pc), 32'hFE);
        @(negedge clk); chk("wrap_00", 32'(bus.out_pc), 32'h00);

        // Reset during the redirect bubble
        bus.redirect = 1'b1; bus.redirect_pc = 8'h40;
        @(negedge clk); bus.redirect = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rr_valid", 32'(bus.out_valid), 32'h0);
        chk("rr_addr", 32'(bus.mem_addr), 32'(RST_PC));
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("rr_restart", 32'(bus.out_pc), 32'(RST_PC));
        chk("rr_rvalid", 32'(bus.out_valid), 32'h1);

        // Reset with a full queue discards everything
        bus.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rf_valid", 32'(bus.out_valid), 32'h0);
        chk("rf_pc", 32'(bus.out_pc), 32'h0);
        chk("rf_inst", 32'(bus.out_inst), 32'h0);
        @(negedge clk); rst = 1'b0;

`ifdef FETCH_PERF_EN
        // Three accepted pops, then a pop that coincides with redirect
        pulse_reset();
        chk("fc_rst", 32'(bus.fetch_count), 32'h0);
        bus.run = 1'b1; bus.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.redirect = 1'b1; bus.redirect_pc = 8'h10;
        @(negedge clk); bus.redirect = 1'b0;
        chk("fc_three", 32'(bus.fetch_count), 32'h3);
`endif

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus.run         = ($urandom_range(7) != 0);
            bus.out_ready   = ($urandom_range(2) != 0);
            bus.redirect    = ($urandom_range(24) == 0);
            bus.redirect_pc = 8'($urandom);
            if ($urandom_range(299) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        bus.redirect = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning fetch address loaded on reset (bit 0 forced to 0).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port run  input  1  fetch enable; 0 suspends new fetches, queue contents retained.
REQ-005 SHALL have port mem_addr  output  8  byte address driven to instruction memory pc input.
REQ-006 SHALL have port mem_inst  input  16  combinational instruction returned for mem_addr (same cycle).
REQ-007 SHALL have port out_valid  output  1  head queue entry valid toward decoder.
REQ-008 SHALL have port out_ready  input  1  decoder accepts head entry when out_valid&&out_ready.
REQ-009 SHALL have port out_inst  output  16  head entry instruction.
REQ-010 SHALL have port out_pc  output  8  head entry byte address.
REQ-011 SHALL have port redirect  input  1  branch/jump taken; flush and reload.
REQ-012 SHALL have port redirect_pc  input  8  new fetch address; bit 0 ignored (treated as 0).

Function
REQ-013 SHALL hold fetch pointer fpc (8 bit); mem_addr = fpc combinationally.
REQ-014 SHALL hold 2-entry FIFO of {inst[15:0], pc[7:0]}; out_* reflect head; out_valid = (count != 0).
REQ-015 SHALL implement FSM states IDLE, FETCH, REDIR.
REQ-016 IDLE: no push; -> FETCH when run=1 (evaluated each cycle).
REQ-017 FETCH: push {mem_inst, fpc} and fpc <= fpc+2 when count<2, or count==2 with pop same cycle; -> IDLE when run=0 (no push that cycle).
REQ-018 fpc increment SHALL wrap modulo 256 (8'hFE -> 8'h00).
REQ-019 Pop and push in same cycle SHALL leave count unchanged and preserve order.
REQ-020 redirect=1 in any state SHALL: clear FIFO (count=0), fpc <= {redirect_pc[7:1],1'b0}, no push, no pop effect, state -> REDIR.
REQ-021 REDIR: one bubble cycle, no push; -> FETCH if run=1 else IDLE.
REQ-022 redirect SHALL take priority over run, push and pop in the same cycle.
REQ-023 Latency: from IDLE with run=1, first entry valid one cycle after entering FETCH; after redirect, first new entry valid 2 edges after the redirect edge.
REQ-024 out_inst/out_pc SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-025 On rst=1 (async): fpc=RESET_PC&8'hFE, count=0, FIFO pointers 0, state=IDLE, out_valid=0, out_inst=16'h0000, out_pc=8'h00.
REQ-026 Reset asserted mid-fetch or mid-REDIR SHALL discard all queued entries; no partial push on the deassertion edge.

Configuration
REQ-027 Macro FETCH_PERF_EN: when defined, SHALL add output fetch_count (16 bit), reset 0, incremented on each accepted pop (out_valid&&out_ready&&!redirect), saturating at 16'hFFFF.
REQ-028 Without FETCH_PERF_EN: port fetch_count and counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset, run=1, out_ready=1, memory holds 16'h7000 at 0x04 -> out_pc sequence 0x00,0x02,0x04 on consecutive cycles; out_inst=16'h7000 at out_pc=0x04.
REQ-030 out_ready=0 for 5 cycles -> count reaches 2, fpc stops at 0x04, out_pc held 0x00; release -> 0x00,0x02,0x04 in order, no loss or duplicate.
REQ-031 redirect=1, redirect_pc=8'h21 with 2 entries queued -> out_valid=0 next cycle, bubble, then out_pc=0x20.
REQ-032 fpc=8'hFE, run=1 -> entries out_pc 0xFE then 0x00.
REQ-033 rst pulsed asynchronously mid-REDIR -> out_valid=0 immediately, restart at RESET_PC after rst release.
REQ-034 FETCH_PERF_EN defined, 3 accepted pops plus 1 pop coincident with redirect -> fetch_count=3.
